// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types, constants and step decode for the quadrature decoder
package quad_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } step_t;

    // Position of a phase pair {A,B} along the up sequence 00->01->11->10.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b01:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Distance modulo 4 along the sequence: 1 = up, 3 = down, 2 = both bits changed.
    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t     s;
        logic [1:0] d;
        d         = phase_idx(cur) - phase_idx(prev);
        s.valid   = (d == 2'd1) || (d == 2'd3);
        s.up      = (d == 2'd1);
        s.illegal = (d == 2'd2);
        return s;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - phase inputs, controls and position outputs of the decoder
// master: drives a_in/b_in/en/clr, observes pos/dir/step/err
// slave : the decoder side
interface quad_decoder_if #(
    parameter int WIDTH = 16
);
    logic             a_in;
    logic             b_in;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] pos;   // two's complement position
    logic             dir;
    logic             step;
    logic             err;

    modport master (
        output a_in, b_in, en, clr,
        input  pos, dir, step, err
    );

    modport slave (
        input  a_in, b_in, en, clr,
        output pos, dir, step, err
    );
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for one asynchronous bit
// clk, rst_n (async active-low), d (async input), q (synchronized output)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder decoder with signed position counter
// clk, rst_n (async active-low); bus (slave): a_in/b_in phases, en count enable,
// clr sync clear, pos position, dir last direction, step per-count pulse, err sticky illegal flag
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    quad_decoder_if.slave    bus
);
    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic [1:0]       cur;
    logic [1:0]       prev, prev_n;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] pos_q, pos_n;
    logic             dir_q, dir_n;
    logic             step_q, step_n;
    logic             err_q, err_n;
    step_t            dec;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.a_in),
        .q     (cur[1])
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.b_in),
        .q     (cur[0])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PRIME;
            cnt    <= '0;
            prev   <= 2'b00;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            prev   <= prev_n;
            pos_q  <= pos_n;
            dir_q  <= dir_n;
            step_q <= step_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        prev_n  = cur;      // prev always follows cur, legal step or not
        pos_n   = pos_q;
        dir_n   = dir_q;
        step_n  = 1'b0;
        err_n   = err_q;
        dec     = decode_step(prev, cur);

        case (state)
            PRIME: begin
                // Wait for the synchronizer to hold real pin values, then take
                // one cycle to seed prev before any decode is trusted.
                if (cnt == CW'(SYNC_STAGES)) begin
                    state_n = TRACK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            TRACK: begin
                if (dec.valid && bus.en) begin
                    pos_n  = dec.up ? pos_q + 1'b1 : pos_q - 1'b1;
                    dir_n  = dec.up ? DIR_UP : DIR_DN;
                    step_n = 1'b1;
                end
                if (dec.illegal) begin
                    err_n = 1'b1;
                end
            end
            default: state_n = PRIME;
        endcase

        // Clear overrides the count and the error, but not dir or step.
        if (bus.clr) begin
            pos_n = '0;
            err_n = 1'b0;
        end
    end

    assign bus.pos  = pos_q;
    assign bus.dir  = dir_q;
    assign bus.step = step_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder (16-bit and 4-bit instances)
module tb_quad_decoder;

    typedef struct packed {
        logic [15:0] pos;
        logic        dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, en, clr;

    int checks = 0;
    int errors = 0;
    int seen_pulses = 0;
    int exp_pulses  = 0;

    exp_t        exp_q[$];
    logic [15:0] mpos;
    logic        mdir;
    logic [1:0]  cur_idx;

    always #5 clk = ~clk;

    quad_decoder_if #(.WIDTH(16)) bus ();
    quad_decoder_if #(.WIDTH(4))  bus_s ();

    assign bus.a_in   = a;
    assign bus.b_in   = b;
    assign bus.en     = en;
    assign bus.clr    = clr;
    assign bus_s.a_in = a;
    assign bus_s.b_in = b;
    assign bus_s.en   = en;
    assign bus_s.clr  = clr;

    quad_decoder #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    quad_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [1:0] idx);
        logic [1:0] c;
        case (idx)
            2'd0:    c = 2'b00;
            2'd1:    c = 2'b01;
            2'd2:    c = 2'b11;
            default: c = 2'b10;
        endcase
        return c;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic up);
        exp_t e;
        cur_idx = up ? cur_idx + 2'd1 : cur_idx - 2'd1;
        {a, b} = code_of(cur_idx);
        if (en) begin
            mpos = up ? mpos + 16'd1 : mpos - 16'd1;
            mdir = up;
            e.pos = mpos;
            e.dir = mdir;
            exp_q.push_back(e);
            exp_pulses++;
        end
        cycles(5);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        mpos = 16'd0;
        cycles(1);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_pos"}, {16'd0, bus.pos}, {16'd0, mpos});
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_pulses"}, seen_pulses, exp_pulses);
        #1;
    endtask

    // Monitor: each step pulse must match the oldest expected step.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.step === 1'b1) begin
                seen_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_step", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("step_pos", {16'd0, bus.pos}, {16'd0, e.pos});
                    check("step_dir", {31'd0, bus.dir}, {31'd0, e.dir});
                    check("step_pos4", {28'd0, bus_s.pos}, {28'd0, e.pos[3:0]});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0;
        cur_idx = 2'd0; mpos = 16'd0; mdir = 1'b0;

        cycles(3);
        @(negedge clk);
        check("rst_pos",  {16'd0, bus.pos}, 32'd0);
        check("rst_dir",  {31'd0, bus.dir}, 32'd0);
        check("rst_step", {31'd0, bus.step}, 32'd0);
        check("rst_err",  {31'd0, bus.err}, 32'd0);
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(6);

        // 8 up steps
        for (int i = 0; i < 8; i++) do_step(1'b1);
        check_state("up8");
        check("up8_pos_abs", {16'd0, bus.pos}, 32'd8);
        check("up8_dir", {31'd0, bus.dir}, 32'd1);
        check("up8_err", {31'd0, bus.err}, 32'd0);

        // from 3, 5 down steps -> -2
        do_clr();
        for (int i = 0; i < 3; i++) do_step(1'b1);
        for (int i = 0; i < 5; i++) do_step(1'b0);
        check_state("down5");
        check("down5_pos_abs", {16'd0, bus.pos}, 32'h0000_FFFE);
        check("down5_dir", {31'd0, bus.dir}, 32'd0);

        // wrap on the 4-bit instance: 7 -> 8 (most negative) -> 7
        do_clr();
        for (int i = 0; i < 7; i++) do_step(1'b1);
        @(negedge clk);
        check("wrap_max", {28'd0, bus_s.pos}, 32'h7);
        #1;
        do_step(1'b1);
        @(negedge clk);
        check("wrap_up", {28'd0, bus_s.pos}, 32'h8);
        #1;
        do_step(1'b0);
        @(negedge clk);
        check("wrap_dn", {28'd0, bus_s.pos}, 32'h7);
        #1;
        check_state("wrap");

        // illegal jump: both phases change
        cur_idx = cur_idx + 2'd2;
        {a, b} = code_of(cur_idx);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("illegal_err", {31'd0, bus.err}, 32'd1);
        check("illegal_pos", {16'd0, bus.pos}, {16'd0, mpos});
        #1;
        cycles(3);
        check_state("illegal");
        do_clr();
        @(negedge clk);
        check("clr_err", {31'd0, bus.err}, 32'd0);
        check("clr_pos", {16'd0, bus.pos}, 32'd0);
        #1;

        // count enable low: tracking continues, position frozen
        en = 1'b0;
        for (int i = 0; i < 4; i++) do_step(1'b1);
        en = 1'b1;
        do_step(1'b1);
        check_state("en");
        check("en_pos_abs", {16'd0, bus.pos}, 32'd1);

        // reset with inputs held at 11
        while (cur_idx != 2'd2) do_step(1'b1);
        rst_n = 1'b0;
        mpos = 16'd0;
        mdir = 1'b0;
        cycles(2);
        @(negedge clk);
        check("midrst_pos", {16'd0, bus.pos}, 32'd0);
        check("midrst_dir", {31'd0, bus.dir}, 32'd0);
        #1;
        rst_n = 1'b1;
        cycles(8);
        check_state("rel");
        do_step(1'b1);
        check_state("after_rst");
        check("after_rst_pos", {16'd0, bus.pos}, 32'd1);
        check("after_rst_err", {31'd0, bus.err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 16, width of the position counter.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops per phase input (minimum 2).
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 a_in  input  1  encoder phase A; asynchronous to clk.
REQ-006 b_in  input  1  encoder phase B; asynchronous to clk.
REQ-007 en  input  1  count enable; when low, phase tracking continues but the position is frozen.
REQ-008 clr  input  1  synchronous clear of the position and the error flag.
REQ-009 pos  output  WIDTH  signed position count, two's complement.
REQ-010 dir  output  1  direction of the last valid step; 1 = up, 0 = down.
REQ-011 step  output  1  one-cycle pulse for each counted step.
REQ-012 err  output  1  sticky flag; set when a phase transition is illegal (both phases change).

Function
REQ-013 a_in and b_in each SHALL pass through a SYNC_STAGES-flop synchronizer before any decode logic.
REQ-014 The decoder SHALL hold a registered previous phase pair, prev[1:0] = {A,B}, and compare it each cycle with the synchronized pair, cur.
REQ-015 The up sequence SHALL be 00->01->11->10->00; each such cur/prev transition is a +1 step.
REQ-016 The down sequence SHALL be the reverse (00->10->11->01->00); each such transition is a -1 step.
REQ-017 cur == prev SHALL produce no step and no change in pos or dir.
REQ-018 A transition in which both bits change SHALL set err, SHALL leave pos and dir unchanged, and SHALL NOT pulse step; prev SHALL still load cur.
REQ-019 On a valid step with en=1: pos updates by ±1, dir takes the step direction, and step pulses high for exactly one cycle, all on the same edge.
REQ-020 On a valid step with en=0: pos, dir and step SHALL be unchanged; prev SHALL still update.
REQ-021 Latency from a phase edge at the pins to the pos/step update SHALL be SYNC_STAGES+1 clk cycles (3 at the default).
REQ-022 pos SHALL wrap modulo 2^WIDTH: max positive +1 gives most negative; most negative -1 gives max positive. No saturation and no flag.
REQ-023 clr=1 SHALL set pos=0 and err=0 on the next edge; dir is unchanged.
REQ-024 If clr and a valid step occur in the same cycle, clr SHALL win (pos=0, err=0), step SHALL still pulse, and dir SHALL update.
REQ-025 If clr and an illegal transition occur in the same cycle, err SHALL end at 0.
REQ-026 Decode state machine states: PRIME and TRACK.
  - PRIME is entered on reset and lasts one cycle after the synchronizer is filled (SYNC_STAGES cycles after reset release).
  - In PRIME, prev loads cur and no step or err is produced; the machine then moves to TRACK.
  - TRACK is held until reset.
REQ-027 A maximum input rate of one phase change per SYNC_STAGES+1 cycles SHALL be counted losslessly; faster changes MAY be flagged as err.

Reset
REQ-028 While rst_n=0, all outputs SHALL be forced asynchronously: pos=0, dir=0, step=0, err=0.
REQ-029 While rst_n=0, all internal state SHALL be forced asynchronously: synchronizer flops=0, prev=00, state=PRIME.
REQ-030 Reset assertion in the middle of a transition SHALL discard that step; after release the block re-primes per REQ-026.
REQ-031 Reset release SHALL be synchronous to clk at the board level; the block adds no reset synchronizer.

Structure
REQ-032 Package quad_pkg SHALL hold:
  - the state encoding (PRIME, TRACK);
  - the direction constants DIR_UP=1 and DIR_DN=0;
  - the step-decode function (prev, cur) -> {valid, up, illegal}.
REQ-033 The synchronizer SHALL be the sub-module sync_ff (parameter STAGES, async active-low reset), instantiated once per phase.

Verification
REQ-034 Scenario: reset, then 8 up-sequence steps with en=1 spaced 5 cycles apart -> pos=8, dir=1, 8 step pulses, err=0.
REQ-035 Scenario: from pos=3, 5 down-sequence steps -> pos=-2 (0xFFFE at WIDTH=16), dir=0.
REQ-036 Scenario: pos=0x7FFF, then one up step -> pos=0x8000; from pos=0x8000, one down step -> pos=0x7FFF.
REQ-037 Scenario: AB jumps 00->11 -> err=1 within 3 cycles, pos unchanged; then clr -> err=0, pos=0.
REQ-038 Scenario: en=0 during 4 up steps, then en=1 and 1 up step -> pos=1, exactly 1 step pulse.
REQ-039 Scenario: rst_n pulsed low mid-sequence with inputs held at 11 -> no step after release; the next 11->10 transition gives pos=+1.
